// File: rtl/intersection_controller.sv
// Two-direction intersection sequencer: prescaled tick, latched requests, all-red clearance.
// Optional pedestrian walk interval inside clearance is built when PED_WALK_EN is defined.
module intersection_controller #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned GREEN_TIME = 30,
  parameter int unsigned CLEAR_TIME = 2,
  parameter int unsigned WALK_TIME  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_request,
  input  logic       ew_request,
`ifdef PED_WALK_EN
  input  logic       ped_request,
  output logic       walk,
`endif
  output logic       ns_enable,
  output logic       ew_enable,
  output logic [6:0] master_timer,
  output logic [1:0] phase
);

  localparam int unsigned PRE_W   = $clog2(TICK_DIV);
  localparam int unsigned TMR_W   = 7;
  // One counter times both the clearance and the walk interval.
  localparam int unsigned CNT_MAX = (WALK_TIME > CLEAR_TIME) ? WALK_TIME : CLEAR_TIME;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_NS_GO = 2'd1,
    S_EW_GO = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PRE_W-1:0]   r_presc;
  logic               r_next_dir;
  logic               w_next_dir_nxt;
  logic [CNT_W-1:0]   r_clear_cnt;
  logic [CNT_W-1:0]   w_clear_cnt_nxt;
  logic               r_ns_req_l;
  logic               r_ew_req_l;
  logic               w_ns_req_nxt;
  logic               w_ew_req_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic               r_ns_en;
  logic               r_ew_en;
  logic               w_ns_en_nxt;
  logic               w_ew_en_nxt;

  logic               w_tick;
  logic               w_cnt_last;
  logic               w_clear_exit;
  logic               w_go_entry;
  logic               w_opp_req;

`ifdef PED_WALK_EN
  logic               r_ped_req_l;
  logic               w_ped_req_nxt;
  logic               r_walk;
  logic               w_walk_nxt;
  logic               w_walk_start;
`endif

  assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

`ifdef PED_WALK_EN
  assign w_cnt_last   = r_walk ? (r_clear_cnt == CNT_W'(WALK_TIME - 1))
                               : (r_clear_cnt == CNT_W'(CLEAR_TIME - 1));
  assign w_clear_exit = w_cnt_last && (r_walk || !r_ped_req_l);
  assign w_walk_start = w_cnt_last && !r_walk && r_ped_req_l;
`else
  assign w_cnt_last   = (r_clear_cnt == CNT_W'(CLEAR_TIME - 1));
  assign w_clear_exit = w_cnt_last;
`endif

  // Opposing demand includes a request arriving on this very cycle.
  assign w_opp_req  = (r_state == S_NS_GO) ? (r_ew_req_l | ew_request)
                                           : (r_ns_req_l | ns_request);
  assign w_go_entry = (r_state == S_CLEAR) && (w_state_nxt != S_CLEAR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: begin
        if (w_tick && w_clear_exit) begin
          w_state_nxt = r_next_dir ? S_EW_GO : S_NS_GO;
        end
      end
      S_NS_GO, S_EW_GO: begin
        if (w_tick && (r_timer == '0)) begin
          w_state_nxt = S_CLEAR;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_timer_nxt     = r_timer;
    w_clear_cnt_nxt = r_clear_cnt;
    w_next_dir_nxt  = r_next_dir;
    w_ns_en_nxt     = (w_state_nxt == S_NS_GO);
    w_ew_en_nxt     = (w_state_nxt == S_EW_GO);
    w_ns_req_nxt    = r_ns_req_l | (ns_request && (r_state != S_NS_GO));
    w_ew_req_nxt    = r_ew_req_l | (ew_request && (r_state != S_EW_GO));
`ifdef PED_WALK_EN
    w_ped_req_nxt   = r_ped_req_l | ped_request;
    w_walk_nxt      = r_walk;
`endif

    case (r_state)
      S_CLEAR: begin
        w_timer_nxt = '0;
        if (w_go_entry) begin
          w_timer_nxt     = TMR_W'(GREEN_TIME);
          w_next_dir_nxt  = ~r_next_dir;
          w_clear_cnt_nxt = '0;
        end else if (w_tick) begin
`ifdef PED_WALK_EN
          if (w_walk_start) begin
            w_clear_cnt_nxt = '0;
            w_walk_nxt      = 1'b1;
          end else
`endif
          if (!w_cnt_last) begin
            w_clear_cnt_nxt = r_clear_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        // Green dwells at 4 until the other direction asks; yellow always runs out.
        if (w_tick && (r_timer != '0) && ((r_timer != TMR_W'(4)) || w_opp_req)) begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
    endcase

    if (w_go_entry && (w_state_nxt == S_NS_GO)) w_ns_req_nxt = 1'b0;
    if (w_go_entry && (w_state_nxt == S_EW_GO)) w_ew_req_nxt = 1'b0;
`ifdef PED_WALK_EN
    if (w_go_entry) begin
      w_ped_req_nxt = 1'b0;
      w_walk_nxt    = 1'b0;
    end
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc     <= '0;
      r_next_dir  <= 1'b0;
      r_clear_cnt <= '0;
      r_ns_req_l  <= 1'b0;
      r_ew_req_l  <= 1'b0;
      r_timer     <= '0;
      r_ns_en     <= 1'b0;
      r_ew_en     <= 1'b0;
`ifdef PED_WALK_EN
      r_ped_req_l <= 1'b0;
      r_walk      <= 1'b0;
`endif
    end else begin
      r_presc     <= w_tick ? '0 : (r_presc + PRE_W'(1));
      r_next_dir  <= w_next_dir_nxt;
      r_clear_cnt <= w_clear_cnt_nxt;
      r_ns_req_l  <= w_ns_req_nxt;
      r_ew_req_l  <= w_ew_req_nxt;
      r_timer     <= w_timer_nxt;
      r_ns_en     <= w_ns_en_nxt;
      r_ew_en     <= w_ew_en_nxt;
`ifdef PED_WALK_EN
      r_ped_req_l <= w_ped_req_nxt;
      r_walk      <= w_walk_nxt;
`endif
    end
  end

  assign ns_enable    = r_ns_en;
  assign ew_enable    = r_ew_en;
  assign master_timer = r_timer;
  assign phase        = r_state;
`ifdef PED_WALK_EN
  assign walk         = r_walk;
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller (TICK_DIV=2, GREEN_TIME=8, CLEAR_TIME=2).
// Adds the walk interval checks when PED_WALK_EN is defined.
module tb_intersection_controller;

  logic       clk;
  logic       reset;
  logic       ns_request;
  logic       ew_request;
  logic       ns_enable;
  logic       ew_enable;
  logic [6:0] master_timer;
  logic [1:0] phase;
`ifdef PED_WALK_EN
  logic       ped_request;
  logic       walk;
  logic       exp_walk;
`endif

  int checks = 0;
  int errors = 0;

  intersection_controller #(
    .TICK_DIV  (2),
    .GREEN_TIME(8),
    .CLEAR_TIME(2),
    .WALK_TIME (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ns_request  (ns_request),
    .ew_request  (ew_request),
`ifdef PED_WALK_EN
    .ped_request (ped_request),
    .walk        (walk),
`endif
    .ns_enable   (ns_enable),
    .ew_enable   (ew_enable),
    .master_timer(master_timer),
    .phase       (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_ns, input logic e_ew,
                            input logic [6:0] e_t, input logic [1:0] e_ph);
    chk({tag, ".ns_enable"},    32'(ns_enable),    32'(e_ns));
    chk({tag, ".ew_enable"},    32'(ew_enable),    32'(e_ew));
    chk({tag, ".master_timer"}, 32'(master_timer), 32'(e_t));
    chk({tag, ".phase"},        32'(phase),        32'(e_ph));
`ifdef PED_WALK_EN
    chk({tag, ".walk"},         32'(walk),         32'(exp_walk));
`endif
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tick is two clocks; callers stay aligned just after a tick edge.
  task automatic tick();
    cyc(2);
  endtask

  initial begin
    reset      = 1'b1;
    ns_request = 1'b0;
    ew_request = 1'b0;
`ifdef PED_WALK_EN
    ped_request = 1'b0;
    exp_walk    = 1'b0;
`endif

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      expect_out($sformatf("reset%0d", i), 1'b0, 1'b0, 7'd0, 2'd0);
    end
    reset = 1'b0;
    tick();
    expect_out("clr_tick1", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("ns_entry", 1'b1, 1'b0, 7'd8, 2'd1);

    // Countdown to 4, then dwell without opposing demand
    for (int v = 7; v >= 4; v--) begin
      tick();
      expect_out($sformatf("ns_cnt%0d", v), 1'b1, 1'b0, 7'(v), 2'd1);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out($sformatf("ns_dwell%0d", i), 1'b1, 1'b0, 7'd4, 2'd1);
    end

    // One-cycle EW pulse during the dwell releases yellow
    ew_request = 1'b1;
    cyc(1);
    ew_request = 1'b0;
    cyc(1);
    expect_out("ns_yel3", 1'b1, 1'b0, 7'd3, 2'd1);
    for (int v = 2; v >= 0; v--) begin
      tick();
      expect_out($sformatf("ns_yel%0d", v), 1'b1, 1'b0, 7'(v), 2'd1);
    end
    tick();
    expect_out("clr_a0", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("clr_a1", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("ew_entry", 1'b0, 1'b1, 7'd8, 2'd2);

    // Reset in the middle of EW_GO at timer 5
    for (int v = 7; v >= 5; v--) begin
      tick();
      expect_out($sformatf("ew_cnt%0d", v), 1'b0, 1'b1, 7'(v), 2'd2);
    end
    reset = 1'b1;
    cyc(1);
    expect_out("mid_reset", 1'b0, 1'b0, 7'd0, 2'd0);
    reset = 1'b0;
    tick();
    expect_out("post_rst_clr", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("post_rst_ns", 1'b1, 1'b0, 7'd8, 2'd1);

    // EW pulse at timer 6 (no dwell); NS pulse while NS is green is ignored
    tick();
    expect_out("ns2_cnt7", 1'b1, 1'b0, 7'd7, 2'd1);
    tick();
    expect_out("ns2_cnt6", 1'b1, 1'b0, 7'd6, 2'd1);
    ew_request = 1'b1;
    ns_request = 1'b1;
    cyc(1);
    ew_request = 1'b0;
    ns_request = 1'b0;
    cyc(1);
    expect_out("ns2_cnt5", 1'b1, 1'b0, 7'd5, 2'd1);
    for (int v = 4; v >= 0; v--) begin
      tick();
      expect_out($sformatf("ns2_cnt%0d", v), 1'b1, 1'b0, 7'(v), 2'd1);
    end
    tick();
    expect_out("clr_b0", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("clr_b1", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("ew2_entry", 1'b0, 1'b1, 7'd8, 2'd2);
    for (int v = 7; v >= 4; v--) begin
      tick();
      expect_out($sformatf("ew2_cnt%0d", v), 1'b0, 1'b1, 7'(v), 2'd2);
    end
    tick();
    expect_out("ew2_dwell", 1'b0, 1'b1, 7'd4, 2'd2);

    // NS demand releases the EW dwell and hands right-of-way back
    ns_request = 1'b1;
    cyc(1);
    ns_request = 1'b0;
    cyc(1);
    expect_out("ew2_yel3", 1'b0, 1'b1, 7'd3, 2'd2);
    for (int v = 2; v >= 0; v--) begin
      tick();
      expect_out($sformatf("ew2_yel%0d", v), 1'b0, 1'b1, 7'(v), 2'd2);
    end
    tick();
    expect_out("clr_c0", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("clr_c1", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("ns3_entry", 1'b1, 1'b0, 7'd8, 2'd1);
    for (int v = 7; v >= 4; v--) begin
      tick();
      expect_out($sformatf("ns3_cnt%0d", v), 1'b1, 1'b0, 7'(v), 2'd1);
    end

    // EW demand (plus pedestrian demand when built) during NS dwell
    ew_request = 1'b1;
`ifdef PED_WALK_EN
    ped_request = 1'b1;
`endif
    cyc(1);
    ew_request = 1'b0;
`ifdef PED_WALK_EN
    ped_request = 1'b0;
`endif
    cyc(1);
    expect_out("ns3_yel3", 1'b1, 1'b0, 7'd3, 2'd1);
    for (int v = 2; v >= 0; v--) begin
      tick();
      expect_out($sformatf("ns3_yel%0d", v), 1'b1, 1'b0, 7'(v), 2'd1);
    end
    tick();
    expect_out("clr_d0", 1'b0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("clr_d1", 1'b0, 1'b0, 7'd0, 2'd0);
`ifdef PED_WALK_EN
    exp_walk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out($sformatf("walk%0d", i), 1'b0, 1'b0, 7'd0, 2'd0);
    end
    exp_walk = 1'b0;
`endif
    tick();
    expect_out("ew3_entry", 1'b0, 1'b1, 7'd8, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences two traffic_light instances, one per direction (NS and EW), at a single intersection.
- Generates each light's enable and the shared 7-bit master_timer.
- Alternates right-of-way on latched vehicle requests, with an all-red clearance interval between phases.
- Time base is an internal tick derived from clk by a prescaler.

Parameters:
TICK_DIV, 50000000, clk cycles per timer tick; legal 2..2^26.
GREEN_TIME, 30, master_timer load value at the start of a go phase; legal 5..127.
CLEAR_TIME, 2, all-red clearance length in ticks; legal 1..15.
WALK_TIME, 10, pedestrian walk length in ticks; used only with PED_WALK_EN.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
ns_request  input  1  vehicle waiting on NS; level or pulse, sampled every clk.
ew_request  input  1  vehicle waiting on EW; level or pulse, sampled every clk.
ns_enable  output  1  enable for the NS traffic_light.
ew_enable  output  1  enable for the EW traffic_light.
master_timer  output  7  countdown shared by both lights. Light decode: >=4 green, 1..3 yellow, 0 red.
phase  output  2  current state: 0 CLEAR, 1 NS_GO, 2 EW_GO.

Behaviour:
- All outputs are registered.
- Reset, one cycle after reset is sampled high:
  - state CLEAR; next_dir NS.
  - ns_enable=0, ew_enable=0, master_timer=0, phase=0.
  - Prescaler, clear counter and request latches all 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-cycle pulse on the cycle where count==TICK_DIV-1.
  - All timer and state updates happen on that same edge.
- Request latches:
  - ns_req_l is set on any cycle with ns_request=1, unless state is NS_GO. Requests for the currently green direction are ignored.
  - ew_req_l is handled symmetrically.
  - A latch is cleared on the edge that enters its direction's GO state. A set request and a clear on the same edge resolve to clear.
- CLEAR state:
  - Both enables 0, master_timer=0.
  - On each tick: if clear_cnt==CLEAR_TIME-1, go to the GO state of next_dir; otherwise clear_cnt+1.
  - CLEAR therefore lasts exactly CLEAR_TIME ticks.
- Entering a GO state (same edge):
  - That direction's enable goes to 1.
  - master_timer loads GREEN_TIME.
  - next_dir toggles.
  - clear_cnt resets to 0.
- NS_GO / EW_GO, on each tick:
  - master_timer>4: decrement.
  - master_timer==4: decrement only if the opposing latch is set; otherwise hold. The light dwells green indefinitely.
  - master_timer in 1..3: decrement unconditionally; yellow is never aborted.
  - master_timer==0: go to CLEAR and drop the enable. Red is therefore shown for exactly 1 tick before clearance.
- Timer arithmetic is unsigned 7-bit and never wraps below 0.
- The opposing latch is evaluated on the tick itself, so a request arriving on the tick cycle counts.
- Reset asserted mid-phase overrides everything and returns to the reset state on the next edge.

Optional Feature:
PED_WALK_EN
- Defined:
  - Adds input ped_request (1 bit, sticky latch ped_req_l, set any cycle) and output walk (1 bit, reset 0).
  - When CLEAR would exit with ped_req_l=1, CLEAR instead extends by WALK_TIME ticks with walk=1. Enables stay 0 and master_timer stays 0.
  - walk drops and ped_req_l clears on the edge entering the next GO.
- Undefined: ports ped_request and walk do not exist; CLEAR always lasts CLEAR_TIME ticks.

Test Plan:
(all with TICK_DIV=2, GREEN_TIME=8, CLEAR_TIME=2)
- Reset held 3 cycles, then released, no requests -> all outputs 0 during reset; at the 2nd tick ns_enable=1, master_timer=8, phase=1.
- No requests after NS_GO entry -> master_timer 8,7,6,5,4, then holds 4 for 20 ticks; ew_enable stays 0.
- 1-cycle ew_request pulse while NS timer holds 4 -> 3,2,1,0 on successive ticks; next tick phase=0 with both enables 0 for 2 ticks; then ew_enable=1, master_timer=8.
- ew_request pulse at master_timer=6 -> counts 5,4,3,2,1,0 with no dwell at 4; ns_request pulsed during NS_GO does not alter the sequence.
- reset pulsed at EW_GO, master_timer=5 -> next edge all outputs 0, phase=0; next GO is NS.
- PED_WALK_EN, ped_request pulse during NS_GO -> CLEAR lasts 2+10 ticks with walk=1 for the last 10; walk=0 on the same edge ew_enable=1.
